matmul_apb_master: RTL and testbench

- APB4 initiator (requester) that drives the APB completer port of the matmul accelerator.
- Converts a simple valid/ready command interface (read/write, addr, data, strobe) into compliant SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Sits between a test/host controller (or a future on-chip CPU bridge) and the matmul register/memory map.

---
 rtl/matmul_pkg.sv | 36 +++
 rtl/matmul_apb_master.sv | 122 ++++++++++++
 tb/tb_matmul_apb_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// ============================================================================
// matmul_pkg : shared widths and APB initiator types for the matmul block
// Rev 1.0
// ============================================================================
`default_nettype none

package matmul_pkg;

  // Bus widths shared by the matmul APB completer and its initiator.
  localparam int MM_ADDR_W = 16;
  localparam int MM_DATA_W = 32;
  localparam int MM_STRB_W = MM_DATA_W / 8;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                 write;
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_DATA_W-1:0] wdata;
    logic [MM_STRB_W-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [MM_DATA_W-1:0] rdata;
    logic                 err;
    logic                 timeout;
  } apb_rsp_t;

endpackage

`default_nettype wire

// File: rtl/matmul_apb_master.sv
// ============================================================================
// matmul_apb_master : valid/ready command to APB4 initiator with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module matmul_apb_master
  import matmul_pkg::*;
#(
  parameter  int ADDR_W         = MM_ADDR_W,
  parameter  int DATA_W         = MM_DATA_W,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int STRB_W         = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [STRB_W-1:0] cmd_strb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [STRB_W-1:0] pstrb_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic [ADDR_W-1:0] paddr_o,
  input  logic              pready_i,
  input  logic              pslverr_i,
  input  logic [DATA_W-1:0] prdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort fires on the ACCESS cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_mst_state_e   state;
  apb_mst_state_e   state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             active;
  logic             accept;
  logic             tmo_hit;

  // Keeps cmd_ready_o low while reset is held, although state already reads IDLE.
  assign cmd_ready_o = active && (state == APB_IDLE);
  assign accept      = cmd_ready_o && cmd_valid_i;
  assign tmo_hit     = (TIMEOUT_CYCLES > 0) && !pready_i && (wait_cnt == TMO_LAST);

  assign psel_o      = (state == APB_SETUP) || (state == APB_ACCESS);
  assign penable_o   = (state == APB_ACCESS);
  assign rsp_valid_o = (state == APB_RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= APB_IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      APB_IDLE:   if (accept) state_nxt = APB_SETUP;
      APB_SETUP:  state_nxt = APB_ACCESS;
      APB_ACCESS: if (pready_i || tmo_hit) state_nxt = APB_RESP;
      APB_RESP:   if (rsp_ready_i) state_nxt = APB_IDLE;
      default:    state_nxt = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        APB_IDLE: begin
          if (accept) begin
            pwrite_o <= cmd_write_i;
            paddr_o  <= cmd_addr_i;
            pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
            pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
          end
        end
        APB_SETUP: wait_cnt <= '0;
        APB_ACCESS: begin
          if (pready_i) begin
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
          end else if (tmo_hit) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_apb_master.sv
// ============================================================================
// tb_matmul_apb_master : directed self-checking bench for matmul_apb_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_matmul_apb_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [15:0] paddr;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int n_checks;
  int n_pass;

  matmul_apb_master #(
    .ADDR_W        (16),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_strb_i   (cmd_strb),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .pstrb_o      (pstrb),
    .pwdata_o     (pwdata),
    .paddr_o      (paddr),
    .pready_i     (pready),
    .pslverr_i    (pslverr),
    .prdata_i     (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b1;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;

    // Reset state
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_psel",      32'(psel),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_paddr",     32'(paddr),     32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Write, zero-wait completer
    issue(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("wr_setup_psel",    32'(psel),    32'd1);
    check("wr_setup_penable", 32'(penable), 32'd0);
    check("wr_setup_ready",   32'(cmd_ready), 32'd0);
    tick();
    check("wr_acc_penable", 32'(penable), 32'd1);
    check("wr_acc_paddr",   32'(paddr),   32'h0010);
    check("wr_acc_pwdata",  pwdata,       32'hDEADBEEF);
    check("wr_acc_pstrb",   32'(pstrb),   32'hF);
    check("wr_acc_pwrite",  32'(pwrite),  32'd1);
    tick();
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_psel",  32'(psel),      32'd0);
    check("wr_rsp_err",   32'(rsp_err),   32'd0);
    check("wr_rsp_rdata", rsp_rdata,      32'd0);
    check("wr_rsp_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("wr_n4_ready", 32'(cmd_ready), 32'd1);
    check("wr_n4_valid", 32'(rsp_valid), 32'd0);

    // Read with 3 wait states; completion lands on the timeout cycle
    issue(1'b0, 16'h0100, 32'hFFFFFFFF, 4'hF);
    pready  = 1'b0;
    pslverr = 1'b1;
    prdata  = 32'hBAD0BAD0;
    tick();
    cmd_valid = 1'b0;
    check("rd_setup_pstrb",  32'(pstrb), 32'd0);
    check("rd_setup_pwdata", pwdata,     32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_penable", 32'(penable), 32'd1);
      check("rd_wait_paddr",   32'(paddr),   32'h0100);
      check("rd_wait_valid",   32'(rsp_valid), 32'd0);
      tick();
    end
    check("rd_last_penable", 32'(penable), 32'd1);
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = 32'h12345678;
    tick();
    pready = 1'b0;
    prdata = 32'h0;
    check("rd_rsp_valid",   32'(rsp_valid),   32'd1);
    check("rd_rsp_rdata",   rsp_rdata,        32'h12345678);
    check("rd_rsp_err",     32'(rsp_err),     32'd0);
    check("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
    tick();

    // Slave error on write
    issue(1'b1, 16'h0004, 32'h00000001, 4'h1);
    pready  = 1'b1;
    pslverr = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pslverr = 1'b0;
    check("err_rsp_valid",   32'(rsp_valid),   32'd1);
    check("err_rsp_err",     32'(rsp_err),     32'd1);
    check("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
    tick();

    // Timeout after exactly 4 ACCESS cycles
    issue(1'b0, 16'h0030, 32'h0, 4'h0);
    pready = 1'b0;
    prdata = 32'h55AA55AA;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("tmo_acc_penable", 32'(penable), 32'd1);
      tick();
    end
    check("tmo_psel",        32'(psel),        32'd0);
    check("tmo_rsp_valid",   32'(rsp_valid),   32'd1);
    check("tmo_rsp_err",     32'(rsp_err),     32'd1);
    check("tmo_rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("tmo_rsp_rdata",   rsp_rdata,        32'd0);
    tick();

    // Response backpressure with a second command pending
    rsp_ready = 1'b0;
    issue(1'b0, 16'h0040, 32'h0, 4'h0);
    pready = 1'b1;
    prdata = 32'hA5A55A5A;
    tick();
    issue(1'b0, 16'h0200, 32'h0, 4'h0);
    tick();
    check("bp_acc_paddr", 32'(paddr), 32'h0040);
    tick();
    prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata,      32'hA5A55A5A);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_accept_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("bp2_setup_psel",  32'(psel),  32'd1);
    check("bp2_setup_paddr", 32'(paddr), 32'h0200);
    prdata = 32'hCAFEF00D;
    tick();
    tick();
    check("bp2_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    tick();

    // Asynchronous reset during ACCESS
    issue(1'b0, 16'h0050, 32'h0, 4'h0);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("ar_pre_penable", 32'(penable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_psel",      32'(psel),      32'd0);
    check("ar_penable",   32'(penable),   32'd0);
    check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    check("ar_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_post_ready", 32'(cmd_ready), 32'd1);
    issue(1'b0, 16'h0008, 32'h0, 4'h0);
    pready = 1'b1;
    prdata = 32'h00C0FFEE;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("ar_rd_valid", 32'(rsp_valid), 32'd1);
    check("ar_rd_rdata", rsp_rdata,      32'h00C0FFEE);
    check("ar_rd_err",   32'(rsp_err),   32'd0);
    tick();
    check("ar_rd_ready", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
